// File: rtl/accumulator_div.sv
// -----------------------------------------------------------------------------
// accumulator_div
// Unsigned divider using repeated subtraction. A START seen in IDLE latches the
// operands. Each RUN cycle then either subtracts the divisor from the running
// remainder or finishes. Divide-by-zero finishes on the first RUN edge with an
// all-ones quotient and the DIVZ flag set.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for START; last result held on QUOT/REM/DIVZ
//   RUN    | subtracting divisor from REM, one step per edge
//   FIN    | one-cycle completion pulse (DONE), then back to IDLE
//
// Ports:
//   PHI       in   clock, rising edge
//   RST       in   synchronous active-high reset
//   START     in   begin a division (accepted only in IDLE)
//   DIVIDEND  in   [WIDTH] unsigned dividend, sampled on the accepting edge
//   DIVISOR   in   [WIDTH] unsigned divisor, sampled on the accepting edge
//   QUOT      out  [WIDTH] quotient
//   REM       out  [WIDTH] remainder
//   BUSY      out  high in RUN
//   DONE      out  high in FIN
//   DIVZ      out  divide-by-zero flag of the last completed operation
// -----------------------------------------------------------------------------
module accumulator_div #(
    parameter int WIDTH = 4
) (
    input  logic             PHI,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic [WIDTH-1:0] QUOT,
    output logic [WIDTH-1:0] REM,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIVZ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_d;
    logic             r_divz;
    logic             w_d_zero;
    logic             w_rem_ge;

    assign w_d_zero = (r_d == '0);
    assign w_rem_ge = (r_rem >= r_d);

    // State register
    always_ff @(posedge PHI) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                // A zero divisor, or a remainder below the divisor, ends the run.
                if (w_d_zero || !w_rem_ge) begin
                    w_next = S_FIN;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (r_state)
            S_RUN:   BUSY = 1'b1;
            S_FIN:   DONE = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture and subtract/increment steps.
    // Subtraction only happens when REM >= D with D nonzero, so REM cannot
    // underflow and QUOT peaks at 2^WIDTH-1 (D=1, maximum dividend).
    always_ff @(posedge PHI) begin
        if (RST) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_d    <= '0;
            r_divz <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_rem  <= DIVIDEND;
                        r_d    <= DIVISOR;
                        r_quot <= '0;
                        r_divz <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_d_zero) begin
                        r_quot <= '1;
                        r_divz <= 1'b1;
                    end else if (w_rem_ge) begin
                        r_rem  <= r_rem - r_d;
                        r_quot <= r_quot + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign QUOT = r_quot;
    assign REM  = r_rem;
    assign DIVZ = r_divz;

endmodule

// File: doc/accumulator_div.md
ACCUMULATOR_DIV -- requirements
Module: accumulator_div

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result bit width.
REQ-002 SHALL have port: PHI  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: START  input  1  request to begin a division; sampled on rising edge of PHI.
REQ-005 SHALL have port: DIVIDEND  input  WIDTH  unsigned dividend; sampled only on the accepting edge.
REQ-006 SHALL have port: DIVISOR  input  WIDTH  unsigned divisor; sampled only on the accepting edge.
REQ-007 SHALL have port: QUOT  output  WIDTH  registered quotient.
REQ-008 SHALL have port: REM  output  WIDTH  registered remainder.
REQ-009 SHALL have port: BUSY  output  1  high while in RUN.
REQ-010 SHALL have port: DONE  output  1  one-cycle pulse, high while in FIN.
REQ-011 SHALL have port: DIVZ  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, FIN.
REQ-013 SHALL accept START only in IDLE: latch DIVIDEND into REM, DIVISOR into internal D register, clear QUOT and DIVZ, go to RUN.
REQ-014 SHALL ignore START while in RUN or FIN; latched operands SHALL NOT change during an operation.
REQ-015 In RUN with D==0, SHALL set QUOT to all ones, keep REM equal to dividend, set DIVZ=1, go to FIN on that edge.
REQ-016 In RUN with D!=0 and REM>=D, SHALL perform REM<=REM-D and QUOT<=QUOT+1, staying in RUN.
REQ-017 In RUN with D!=0 and REM<D, SHALL hold QUOT/REM and go to FIN.
REQ-018 Comparison and subtraction SHALL be unsigned, WIDTH bits; REM SHALL never underflow; QUOT SHALL never wrap (max 2^WIDTH-1 when D=1).
REQ-019 FIN SHALL last exactly one cycle, then go to IDLE unconditionally; START during FIN SHALL be ignored.
REQ-020 Latency: with q = final quotient (q=0 for divide-by-zero), DONE SHALL be high in the cycle following the (q+1)th rising edge after the accepting edge; WIDTH=4 worst case 16 edges.
REQ-021 BUSY SHALL be 1 exactly in RUN; DONE SHALL be 1 exactly in FIN; never both.
REQ-022 QUOT, REM, DIVZ SHALL hold the last result in IDLE until the next accepted START.
REQ-023 Results SHALL satisfy DIVIDEND == QUOT*DIVISOR + REM and REM < DIVISOR whenever DIVZ=0.

Reset
REQ-024 RST=1 at a rising edge SHALL force IDLE, QUOT=0, REM=0, D=0, DIVZ=0, BUSY=0, DONE=0, overriding all other inputs including START.
REQ-025 RST asserted mid-RUN or during FIN SHALL abort the operation with no DONE pulse.
REQ-026 After RST deasserts, the first edge with START=1 SHALL be accepted normally.

Verification
REQ-027 START, 13/4 -> BUSY high for 4 cycles; DONE pulse after edge 4 post-accept; QUOT=3, REM=1, DIVZ=0.
REQ-028 START, 15/1 -> DONE after edge 16 post-accept; QUOT=15, REM=0; BUSY high 16 cycles.
REQ-029 START, 3/7 -> DONE after edge 1 post-accept; QUOT=0, REM=3; BUSY high 1 cycle.
REQ-030 START, 9/0 -> DONE after edge 1 post-accept; QUOT=4'hF, REM=9, DIVZ=1.
REQ-031 START 12/3, then START 15/5 held high during RUN and FIN -> second request ignored; QUOT=4, REM=0 held in IDLE; START on a later edge in IDLE yields QUOT=3, REM=0.
REQ-032 START 14/2, RST=1 on edge 3 post-accept -> no DONE; all outputs 0; state IDLE; subsequent 6/4 yields QUOT=1, REM=2.
